// File: rtl/exe_mul_seq_if.sv
// EX-stage multiply sequencer bus: pipeline-side operands and controls in, stall/result out.
// MUL_HI_EN adds the upper product half (mul_result_hi).
interface exe_mul_seq_if #(
    parameter int unsigned XLEN = 32
);
    logic            ex_valid;
    logic [31:0]     ex_ir;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            flush;
    logic            stall;
    logic            mul_done;
    logic [XLEN-1:0] mul_result;
    logic            busy;
`ifdef MUL_HI_EN
    logic [XLEN-1:0] mul_result_hi;
`endif

    modport master (
        output ex_valid,
        output ex_ir,
        output op_a,
        output op_b,
        output flush,
        input  stall,
        input  mul_done,
        input  mul_result,
`ifdef MUL_HI_EN
        input  mul_result_hi,
`endif
        input  busy
    );

    modport slave (
        input  ex_valid,
        input  ex_ir,
        input  op_a,
        input  op_b,
        input  flush,
        output stall,
        output mul_done,
        output mul_result,
`ifdef MUL_HI_EN
        output mul_result_hi,
`endif
        output busy
    );
endinterface

// File: rtl/exe_mul_seq.sv
// Multi-cycle shift-add multiply sequencer for the EXE stage; stalls the pipe while busy.
// Optional MUL_HI_EN: 2*XLEN accumulator, upper product half exported on mul_result_hi.
module exe_mul_seq #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input logic          clk,
    input logic          rst_n,
    exe_mul_seq_if.slave bus
);
    localparam int unsigned CYCLES = XLEN / BITS_PER_CYCLE;
    localparam int unsigned CNT_W  = (CYCLES > 1) ? $clog2(CYCLES) : 1;
`ifdef MUL_HI_EN
    localparam int unsigned ACC_W  = 2 * XLEN;
`else
    localparam int unsigned ACC_W  = XLEN;
`endif

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q;
    logic [ACC_W-1:0]   acc_q;
    logic [ACC_W-1:0]   mcand_q;
    logic [XLEN-1:0]    mplier_q;
    logic [ACC_W-1:0]   pp;
    logic               is_mul;
    logic               start;
    logic               last_cycle;
    logic               unused_ir;

    assign is_mul     = bus.ex_valid & ~bus.ex_ir[31] & (bus.ex_ir[29:26] == 4'd2);
    assign start      = is_mul & ~bus.flush;
    assign last_cycle = (count_q == CNT_W'(CYCLES - 1));
    assign unused_ir  = ^{bus.ex_ir[30], bus.ex_ir[25:0]};

    // Partial product for the multiplier bits retired this cycle, built from shifted adds.
    always_comb begin
        pp = '0;
        for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
            if (mplier_q[i]) begin
                pp = pp + (mcand_q << i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start) state_d = StBusy;
            StBusy: begin
                if (bus.flush) begin
                    state_d = StIdle;
                end else if (last_cycle) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (state_q == StIdle && start) begin
            count_q  <= '0;
            acc_q    <= '0;
            mcand_q  <= ACC_W'(bus.op_a);
            mplier_q <= bus.op_b;
        end else if (state_q == StBusy) begin
            count_q  <= count_q + 1'b1;
            acc_q    <= acc_q + pp;
            mcand_q  <= mcand_q << BITS_PER_CYCLE;
            mplier_q <= mplier_q >> BITS_PER_CYCLE;
        end
    end

    // The idle-cycle stall is combinational, so gate it with reset to drop it asynchronously.
    always_comb begin
        bus.stall      = 1'b0;
        bus.mul_done   = 1'b0;
        bus.busy       = 1'b0;
        bus.mul_result = '0;
`ifdef MUL_HI_EN
        bus.mul_result_hi = '0;
`endif
        unique case (state_q)
            StIdle: bus.stall = start & rst_n;
            StBusy: begin
                bus.stall = 1'b1;
                bus.busy  = 1'b1;
            end
            StDone: begin
                bus.mul_done   = 1'b1;
                bus.busy       = 1'b1;
                bus.mul_result = acc_q[XLEN-1:0];
`ifdef MUL_HI_EN
                bus.mul_result_hi = acc_q[ACC_W-1:XLEN];
`endif
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_exe_mul_seq.sv
// Bench for exe_mul_seq: table vectors, hand-written corner sequences and random operands,
// run on a BITS_PER_CYCLE=1 and a BITS_PER_CYCLE=4 instance.
module tb_exe_mul_seq;
    localparam logic [31:0] MUL_IR  = 32'h0800_0000;
    localparam logic [31:0] ADD_IR  = 32'h0000_0020;
    localparam logic [31:0] HIOP_IR = 32'h8800_0000;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
    } vec_t;

    logic clk;
    logic rst_n;
    int   cfg;
    int   cyc;
    int   last_done;
    int   n_checks;
    int   n_fail;

    exe_mul_seq_if #(.XLEN(32)) bus1 ();
    exe_mul_seq_if #(.XLEN(32)) bus4 ();

    exe_mul_seq #(.XLEN(32), .BITS_PER_CYCLE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    exe_mul_seq #(.XLEN(32), .BITS_PER_CYCLE(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    logic        stall, mul_done, busy;
    logic [31:0] res, res_hi;
    assign stall    = (cfg == 1) ? bus4.stall : bus1.stall;
    assign mul_done = (cfg == 1) ? bus4.mul_done : bus1.mul_done;
    assign busy     = (cfg == 1) ? bus4.busy : bus1.busy;
    assign res      = (cfg == 1) ? bus4.mul_result : bus1.mul_result;
`ifdef MUL_HI_EN
    assign res_hi   = (cfg == 1) ? bus4.mul_result_hi : bus1.mul_result_hi;
`else
    assign res_hi   = '0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %0h, expected %0h (cycle %0d)", tag, name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ir, input logic [31:0] a,
                         input logic [31:0] b, input logic f);
        bus1.ex_valid = v && (cfg == 0);
        bus4.ex_valid = v && (cfg == 1);
        bus1.ex_ir = ir;  bus4.ex_ir = ir;
        bus1.op_a  = a;   bus4.op_a  = a;
        bus1.op_b  = b;   bus4.op_b  = b;
        bus1.flush = f;   bus4.flush = f;
    endtask

    task automatic idle(input int n, input logic v, input logic [31:0] ir, input string tag);
        for (int i = 0; i < n; i++) begin
            step();
            drive(v, ir, $urandom, $urandom, 1'b0);
            #2;
            chk(tag, "stall", 64'(stall), 64'd0);
            chk(tag, "busy", 64'(busy), 64'd0);
            chk(tag, "mul_done", 64'(mul_done), 64'd0);
        end
    endtask

    // One MUL from the start cycle through the done cycle; flush_at/rst_at index BUSY cycles
    // (1..ncyc), flush_at == ncyc+1 flushes in the done cycle. Negative means never.
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [31:0] lo,
                           input logic [31:0] hi, input int flush_at, input int rst_at,
                           input string tag);
        int ncyc;
        ncyc = (cfg == 1) ? 8 : 32;
        step();
        drive(1'b1, MUL_IR, a, b, 1'b0);
        #2;
        chk(tag, "start_stall", 64'(stall), 64'd1);
        chk(tag, "start_busy", 64'(busy), 64'd0);
        for (int k = 1; k <= ncyc + 1; k++) begin
            step();
            // Operands keep changing while stalled; the sequencer must ignore them.
            drive(1'b1, MUL_IR, $urandom, $urandom, k == flush_at);
            #2;
            if (k <= ncyc) begin
                chk(tag, "busy_stall", 64'(stall), 64'd1);
                chk(tag, "busy_busy", 64'(busy), 64'd1);
                chk(tag, "busy_done", 64'(mul_done), 64'd0);
                if (k == rst_at) begin
                    rst_n = 1'b0;
                    #1;
                    chk(tag, "rst_stall", 64'(stall), 64'd0);
                    chk(tag, "rst_busy", 64'(busy), 64'd0);
                    chk(tag, "rst_done", 64'(mul_done), 64'd0);
                    chk(tag, "rst_result", 64'(res), 64'd0);
`ifdef MUL_HI_EN
                    chk(tag, "rst_result_hi", 64'(res_hi), 64'd0);
`endif
                    drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
                    step();
                    rst_n = 1'b1;
                    return;
                end
                if (k == flush_at) begin
                    step();
                    drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
                    #2;
                    chk(tag, "flush_stall", 64'(stall), 64'd0);
                    chk(tag, "flush_busy", 64'(busy), 64'd0);
                    chk(tag, "flush_done", 64'(mul_done), 64'd0);
                    return;
                end
            end else begin
                chk(tag, "done_pulse", 64'(mul_done), 64'd1);
                chk(tag, "done_stall", 64'(stall), 64'd0);
                chk(tag, "done_result", 64'(res), 64'(lo));
`ifdef MUL_HI_EN
                chk(tag, "done_result_hi", 64'(res_hi), 64'(hi));
`endif
                last_done = cyc;
            end
        end
    endtask

    initial begin
        vec_t        vecs[8];
        int          d1;
        logic [63:0] p;
        logic [31:0] a, b;

        vecs[0] = '{32'd7,         32'd6,         32'd42,        32'd0};
        vecs[1] = '{32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFE, 32'd1};
        vecs[2] = '{32'd3,         32'd5,         32'd15,        32'd0};
        vecs[3] = '{32'h0001_0000, 32'h0001_0000, 32'd0,         32'd1};
        vecs[4] = '{32'd9,         32'd9,         32'd81,        32'd0};
        vecs[5] = '{32'h8000_0000, 32'h8000_0000, 32'd0,         32'h4000_0000};
        vecs[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFE};
        vecs[7] = '{32'd0,         32'h0000_1234, 32'd0,         32'd0};

        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        cfg      = 0;
        rst_n    = 1'b0;
        // A MUL presented during reset must not raise stall.
        drive(1'b1, MUL_IR, 32'd7, 32'd6, 1'b0);
        #12;
        chk("reset", "stall", 64'(stall), 64'd0);
        chk("reset", "busy", 64'(busy), 64'd0);
        chk("reset", "mul_done", 64'(mul_done), 64'd0);
        chk("reset", "result", 64'(res), 64'd0);
`ifdef MUL_HI_EN
        chk("reset", "result_hi", 64'(res_hi), 64'd0);
`endif
        drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
        step();
        rst_n = 1'b1;
        idle(2, 1'b0, 32'd0, "post_reset");

        for (int c = 0; c < 2; c++) begin
            cfg = c;
            for (int i = 0; i < 8; i++) begin
                run_mul(vecs[i].a, vecs[i].b, vecs[i].lo, vecs[i].hi, -1, -1, "table");
                idle(1, 1'b0, 32'd0, "table_after");
            end

            idle(6, 1'b1, ADD_IR, "non_mul_add");
            idle(3, 1'b1, HIOP_IR, "non_mul_bit31");
            idle(3, 1'b0, MUL_IR, "mul_not_valid");

            // Abort mid-operation, then make sure no late done pulse appears.
            run_mul(32'd7, 32'd6, 32'd42, 32'd0, (c == 1) ? 4 : 10, -1, "flush_busy");
            idle((c == 1) ? 10 : 34, 1'b0, 32'd0, "flush_quiet");

            run_mul(32'd7, 32'd6, 32'd42, 32'd0, (c == 1) ? 9 : 33, -1, "flush_done");
            idle(1, 1'b0, 32'd0, "flush_done_after");

            // Back-to-back: second MUL starts in the IDLE cycle right after DONE.
            run_mul(32'd3, 32'd5, 32'd15, 32'd0, -1, -1, "b2b_first");
            d1 = last_done;
            run_mul(32'h0001_0000, 32'h0001_0000, 32'd0, 32'd1, -1, -1, "b2b_second");
            chk("b2b", "done_spacing", 64'(last_done - d1), (c == 1) ? 64'd10 : 64'd34);
            idle(1, 1'b0, 32'd0, "b2b_after");

            run_mul(32'd9, 32'd9, 32'd81, 32'd0, -1, (c == 1) ? 5 : 20, "reset_mid");
            run_mul(32'd9, 32'd9, 32'd81, 32'd0, -1, -1, "after_reset");
            idle(1, 1'b0, 32'd0, "after_reset_idle");

            for (int i = 0; i < 12; i++) begin
                a = $urandom;
                b = (i % 3 == 0) ? 32'($urandom_range(0, 255)) : $urandom;
                p = 64'(a) * 64'(b);
                run_mul(a, b, p[31:0], p[63:32], -1, -1, "random");
                idle(1, 1'b0, 32'd0, "random_after");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
